// File: rtl/ysyx_23060171_mem_pkg.sv
// Shared definitions for the LSU data-memory path: response codes,
// responder FSM states and the default data-memory base address.
package ysyx_23060171_mem_pkg;

    localparam logic [1:0]  RESP_OKAY         = 2'b00;
    localparam logic [1:0]  RESP_DECERR       = 2'b11;
    localparam logic [31:0] MEM_ADDR_BASE_DEF = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } mem_state_t;

    // Range test done as compare-before-subtract so addresses below the base
    // cannot wrap into the window; the window size is 33 bits wide.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] bytes);
        logic [31:0] off;
        off = addr - base;
        return (addr >= base) && ({1'b0, off} < bytes);
    endfunction

endpackage

// File: rtl/ysyx_23060171_sram_array.sv
// Word-organised SRAM: byte-lane write port and a registered read port.
// Contents are intentionally not reset.
module ysyx_23060171_sram_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wstrb,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    // Byte-strobed write and synchronous read, both on the rising edge
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_23060171_sram_responder.sv
// Single-outstanding AXI4-Lite-style data-memory slave with a fixed,
// programmable response latency. Writes beat simultaneous reads.
module ysyx_23060171_sram_responder
    import ysyx_23060171_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = MEM_ADDR_BASE_DEF,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_araddr,
    input  logic        i_arvalid,
    output logic        o_arready,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_rresp,
    output logic        o_rvalid,
    input  logic        i_rready,
    input  logic [31:0] i_awaddr,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    input  logic        i_wvalid,
    output logic        o_wready,
    output logic [1:0]  o_bresp,
    output logic        o_bvalid,
    input  logic        i_bready
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  LAT       = 4'(LATENCY);

    mem_state_t  r_state;
    logic [3:0]  r_cnt;
    logic        r_in_range;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic        r_rvalid;
    logic [1:0]  r_bresp;
    logic        r_bvalid;

    logic          w_idle;
    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_ar_in;
    logic          w_aw_in;
    logic [AW-1:0] w_ar_idx;
    logic [AW-1:0] w_aw_idx;
    logic [31:0]   w_arr_rdata;

    // Accept decisions and address decode for the IDLE handshake
    always_comb begin
        w_idle   = (r_state == IDLE);
        w_wr_acc = w_idle & i_awvalid & i_wvalid;
        w_rd_acc = w_idle & i_arvalid & ~(i_awvalid & i_wvalid);
        w_ar_in  = addr_in_range(i_araddr, ADDR_BASE, WIN_BYTES);
        w_aw_in  = addr_in_range(i_awaddr, ADDR_BASE, WIN_BYTES);
        w_ar_idx = AW'((i_araddr - ADDR_BASE) >> 2);
        w_aw_idx = AW'((i_awaddr - ADDR_BASE) >> 2);
    end

    // Ready lines are held low while reset is asserted
    assign o_arready = i_rst_n & w_rd_acc;
    assign o_awready = i_rst_n & w_wr_acc;
    assign o_wready  = i_rst_n & w_wr_acc;

    ysyx_23060171_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_wr_acc & w_aw_in),
        .i_waddr (w_aw_idx),
        .i_wdata (i_wdata),
        .i_wstrb (i_wstrb),
        .i_re    (w_rd_acc),
        .i_raddr (w_ar_idx),
        .o_rdata (w_arr_rdata)
    );

    // Transaction FSM: accept, count down latency, hold response until taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_in_range <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_bvalid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wr_acc) begin
                        r_in_range <= w_aw_in;
                        r_cnt      <= LAT;
                        r_state    <= WR_WAIT;
                    end else if (w_rd_acc) begin
                        r_in_range <= w_ar_in;
                        r_cnt      <= LAT;
                        r_state    <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata  <= r_in_range ? w_arr_rdata : '0;
                        r_rresp  <= r_in_range ? RESP_OKAY : RESP_DECERR;
                        r_rvalid <= 1'b1;
                        r_state  <= RD_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RD_RESP: begin
                    if (i_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (r_cnt == '0) begin
                        r_bresp  <= r_in_range ? RESP_OKAY : RESP_DECERR;
                        r_bvalid <= 1'b1;
                        r_state  <= WR_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WR_RESP: begin
                    if (i_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rresp  = r_rresp;
    assign o_rvalid = r_rvalid;
    assign o_bresp  = r_bresp;
    assign o_bvalid = r_bvalid;

endmodule

// File: tb/tb_ysyx_23060171_sram_responder.sv
// Directed bench for the SRAM responder (default parameters, LATENCY=2).
module tb_ysyx_23060171_sram_responder;

    localparam int LAT = 2;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_araddr;
    logic        i_arvalid;
    logic        o_arready;
    logic [31:0] o_rdata;
    logic [1:0]  o_rresp;
    logic        o_rvalid;
    logic        i_rready;
    logic [31:0] i_awaddr;
    logic        i_awvalid;
    logic        o_awready;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        i_wvalid;
    logic        o_wready;
    logic [1:0]  o_bresp;
    logic        o_bvalid;
    logic        i_bready;

    int vectors = 0;
    int errors  = 0;

    always #5 i_clk = ~i_clk;

    ysyx_23060171_sram_responder #(
        .ADDR_BASE   (32'h8000_0000),
        .DEPTH_WORDS (1024),
        .LATENCY     (LAT)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_araddr  (i_araddr),
        .i_arvalid (i_arvalid),
        .o_arready (o_arready),
        .o_rdata   (o_rdata),
        .o_rresp   (o_rresp),
        .o_rvalid  (o_rvalid),
        .i_rready  (i_rready),
        .i_awaddr  (i_awaddr),
        .i_awvalid (i_awvalid),
        .o_awready (o_awready),
        .i_wdata   (i_wdata),
        .i_wstrb   (i_wstrb),
        .i_wvalid  (i_wvalid),
        .o_wready  (o_wready),
        .o_bresp   (o_bresp),
        .o_bvalid  (o_bvalid),
        .i_bready  (i_bready)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Full write transaction; ok=0 if either phase exceeds its cycle budget
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] r,
                            output bit ok);
        ok = 1'b0;
        r  = 2'b01;
        i_awaddr = a; i_wdata = d; i_wstrb = s;
        i_awvalid = 1'b1; i_wvalid = 1'b1; i_bready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (o_awready && o_wready) begin ok = 1'b1; step(); break; end
            step();
        end
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        if (!ok) return;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (o_bvalid) begin r = o_bresp; ok = 1'b1; step(); break; end
            step();
        end
    endtask

    // Full read transaction; lat = edges from ar handshake to rvalid seen
    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] r, output int lat, output bit ok);
        ok = 1'b0; lat = 0; d = '0; r = 2'b01;
        i_araddr = a; i_arvalid = 1'b1; i_rready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (o_arready) begin ok = 1'b1; step(); break; end
            step();
        end
        i_arvalid = 1'b0;
        if (!ok) return;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (o_rvalid) begin d = o_rdata; r = o_rresp; ok = 1'b1; step(); break; end
            lat++;
            step();
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_araddr = 32'h8000_0000; i_awaddr = 32'h8000_0000;
        i_wdata = '0; i_wstrb = '0;
        i_arvalid = 1'b1; i_awvalid = 1'b0; i_wvalid = 1'b0;
        i_rready = 1'b1; i_bready = 1'b1;
        #12;
        vectors++;
        if (o_arready !== 1'b0) begin errors++; $display("FAIL reset_arready got %b want 0", o_arready); end
        vectors++;
        if (o_rvalid !== 1'b0 || o_bvalid !== 1'b0) begin
            errors++; $display("FAIL reset_valids got r=%b b=%b want 0/0", o_rvalid, o_bvalid);
        end
        vectors++;
        if (o_rdata !== 32'h0 || o_rresp !== 2'b00 || o_bresp !== 2'b00) begin
            errors++; $display("FAIL reset_data got rdata=%h rresp=%b bresp=%b want 0", o_rdata, o_rresp, o_bresp);
        end
        i_arvalid = 1'b0; i_awvalid = 1'b1; i_wvalid = 1'b1;
        #1;
        vectors++;
        if (o_awready !== 1'b0 || o_wready !== 1'b0) begin
            errors++; $display("FAIL reset_awready got aw=%b w=%b want 0/0", o_awready, o_wready);
        end
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        #8 i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, r, ok);
        vectors++;
        if (!ok || r !== 2'b00) begin errors++; $display("FAIL basic_bresp got %b ok=%0d want 00", r, ok); end
        do_read(32'h8000_0010, d, r, lat, ok);
        vectors++;
        if (!ok || d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_rdata got %h want deadbeef", d); end
        vectors++;
        if (r !== 2'b00) begin errors++; $display("FAIL basic_rresp got %b want 00", r); end
        vectors++;
        if (lat != LAT + 1) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT + 1); end
    endtask

    task automatic test_strobe();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        do_write(32'h8000_0020, 32'h1122_3344, 4'hF, r, ok);
        do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, r, ok);
        do_read(32'h8000_0022, d, r, lat, ok);
        vectors++;
        if (!ok || d !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_merge got %h want 11bb33dd", d); end
        do_write(32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, r, ok);
        vectors++;
        if (!ok || r !== 2'b00) begin errors++; $display("FAIL strobe_zero_bresp got %b want 00", r); end
        do_read(32'h8000_0020, d, r, lat, ok);
        vectors++;
        if (!ok || d !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_zero_data got %h want 11bb33dd", d); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        do_write(32'h8000_0000, 32'h0BAD_F00D, 4'hF, r, ok);
        do_write(32'h8000_0FFC, 32'h5A5A_A5A5, 4'hF, r, ok);
        vectors++;
        if (!ok || r !== 2'b00) begin errors++; $display("FAIL oor_last_word_bresp got %b want 00", r); end
        do_read(32'h7FFF_FFFC, d, r, lat, ok);
        vectors++;
        if (!ok || r !== 2'b11 || d !== 32'h0) begin
            errors++; $display("FAIL oor_below got rresp=%b rdata=%h want 11/0", r, d);
        end
        do_read(32'h8000_1000, d, r, lat, ok);
        vectors++;
        if (!ok || r !== 2'b11 || d !== 32'h0) begin
            errors++; $display("FAIL oor_above got rresp=%b rdata=%h want 11/0", r, d);
        end
        do_write(32'h8000_1000, 32'h5555_5555, 4'hF, r, ok);
        vectors++;
        if (!ok || r !== 2'b11) begin errors++; $display("FAIL oor_bresp got %b want 11", r); end
        do_read(32'h8000_0000, d, r, lat, ok);
        vectors++;
        if (!ok || d !== 32'h0BAD_F00D) begin errors++; $display("FAIL oor_word0 got %h want 0badf00d", d); end
        do_read(32'h8000_0FFC, d, r, lat, ok);
        vectors++;
        if (!ok || d !== 32'h5A5A_A5A5 || r !== 2'b00) begin
            errors++; $display("FAIL oor_last_word got %h/%b want 5a5aa5a5/00", d, r);
        end
    endtask

    task automatic test_simultaneous();
        bit seen_ar = 1'b0; bit ok = 1'b0; int lat = 0;
        i_araddr = 32'h8000_0030; i_arvalid = 1'b1; i_rready = 1'b1;
        i_awaddr = 32'h8000_0030; i_wdata = 32'hCAFE_F00D; i_wstrb = 4'hF;
        i_awvalid = 1'b1; i_wvalid = 1'b1; i_bready = 1'b1;
        #1;
        vectors++;
        if (o_awready !== 1'b1 || o_wready !== 1'b1 || o_arready !== 1'b0) begin
            errors++; $display("FAIL simul_priority got aw=%b w=%b ar=%b want 1/1/0", o_awready, o_wready, o_arready);
        end
        step();
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (o_arready) seen_ar = 1'b1;
            if (o_bvalid) begin ok = 1'b1; step(); break; end
            step();
        end
        vectors++;
        if (!ok || seen_ar) begin errors++; $display("FAIL simul_ar_held got bdone=%0d ar_seen=%0d want 1/0", ok, seen_ar); end
        vectors++;
        if (o_arready !== 1'b1) begin errors++; $display("FAIL simul_ar_after_b got %b want 1", o_arready); end
        step();
        i_arvalid = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (o_rvalid) begin ok = 1'b1; break; end
            lat++;
            step();
        end
        vectors++;
        if (!ok || o_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL simul_rdata got %h want cafef00d", o_rdata); end
        step();
    endtask

    task automatic test_backpressure();
        bit ok = 1'b0; bit stable = 1'b1; logic [31:0] held;
        i_araddr = 32'h8000_0010; i_arvalid = 1'b1; i_rready = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (o_arready) begin step(); break; end
            step();
        end
        i_araddr = 32'h8000_0020;
        for (int n = 0; n < 50; n++) begin
            if (o_rvalid) begin ok = 1'b1; break; end
            step();
        end
        held = o_rdata;
        for (int n = 0; n < 5; n++) begin
            if (o_rvalid !== 1'b1 || o_rdata !== held || o_arready !== 1'b0) stable = 1'b0;
            step();
        end
        vectors++;
        if (!ok || !stable) begin errors++; $display("FAIL bp_hold got valid_seen=%0d stable=%0d want 1/1", ok, stable); end
        vectors++;
        if (held !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_rdata got %h want deadbeef", held); end
        i_rready = 1'b1;
        step();
        vectors++;
        if (o_rvalid !== 1'b0 || o_arready !== 1'b1) begin
            errors++; $display("FAIL bp_release got rvalid=%b arready=%b want 0/1", o_rvalid, o_arready);
        end
        i_arvalid = 1'b0;
        step();
    endtask

    task automatic test_reset_midflight();
        logic [31:0] d; logic [1:0] r; int lat; bit ok;
        i_araddr = 32'h8000_0010; i_arvalid = 1'b1; i_rready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (o_arready) begin step(); break; end
            step();
        end
        i_arvalid = 1'b0;
        step();
        #2 i_rst_n = 1'b0;
        #1;
        vectors++;
        if (o_rvalid !== 1'b0 || o_arready !== 1'b0) begin
            errors++; $display("FAIL midrst_read got rvalid=%b arready=%b want 0/0", o_rvalid, o_arready);
        end
        #3 i_rst_n = 1'b1;
        step();
        do_read(32'h8000_0010, d, r, lat, ok);
        vectors++;
        if (!ok || d !== 32'hDEAD_BEEF || lat != LAT + 1) begin
            errors++; $display("FAIL midrst_fresh_read got %h lat=%0d want deadbeef lat=%0d", d, lat, LAT + 1);
        end
        // Write committed at accept must survive a reset during its wait
        i_awaddr = 32'h8000_0040; i_wdata = 32'h1234_5678; i_wstrb = 4'hF;
        i_awvalid = 1'b1; i_wvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (o_awready) begin step(); break; end
            step();
        end
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        vectors++;
        if (o_bvalid !== 1'b0) begin errors++; $display("FAIL midrst_bvalid got %b want 0", o_bvalid); end
        #3 i_rst_n = 1'b1;
        step();
        do_read(32'h8000_0040, d, r, lat, ok);
        vectors++;
        if (!ok || d !== 32'h1234_5678) begin errors++; $display("FAIL midrst_committed got %h want 12345678", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strobe();
        test_out_of_range();
        test_simultaneous();
        test_backpressure();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
